// File: rtl/axis_gen_pkg.sv
// Shared definitions for the AXI-Stream pattern generator: FSM encoding,
// data-pattern selectors and the 32-bit Galois LFSR constants.
package axis_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } gen_state_t;

   localparam logic [1:0] MODE_INC  = 2'd0;
   localparam logic [1:0] MODE_LFSR = 2'd1;
   localparam logic [1:0] MODE_IDX  = 2'd2;

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/axis_gen_lfsr.sv
// 32-bit Galois LFSR: reloads the seed on load, steps once per advance.
module axis_gen_lfsr
   import axis_gen_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= LFSR_SEED;
      end else if (load) begin
         value <= LFSR_SEED;
      end else if (advance) begin
         value <= lfsr_step(value);
      end
   end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream master that emits cfg_pkts packets of cfg_len words after a start
// pulse, with an optional idle gap between packets and a selectable data pattern.
module axis_pattern_gen
   import axis_gen_pkg::*;
#(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int C_M_START_COUNT      = 32,
   parameter int LEN_WIDTH            = 8,
   parameter int GAP_WIDTH            = 8
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESET,
   input  logic                              start,
   input  logic [LEN_WIDTH-1:0]              cfg_len,
   input  logic [15:0]                       cfg_pkts,
   input  logic [GAP_WIDTH-1:0]              cfg_gap,
   input  logic [1:0]                        cfg_mode,
   output logic                              M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY,
   output logic                              busy,
   output logic                              done,
   output logic [15:0]                       pkt_count,
   output gen_state_t                        state_dbg
);

   localparam int W      = C_M_AXIS_TDATA_WIDTH;
   localparam int HALF   = W / 2;
   localparam int WAIT_W = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;

   gen_state_t           state, state_n;
   logic [LEN_WIDTH-1:0] len_q;
   logic [15:0]          pkts_q;
   logic [GAP_WIDTH-1:0] gap_q;
   logic [1:0]           mode_q;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [GAP_WIDTH-1:0] gap_cnt;
   // word/packet/beat numbers of the next beat to be loaded into TDATA
   logic [LEN_WIDTH-1:0] word_nxt;
   logic [15:0]          pkt_nxt;
   logic [W-1:0]         beat_nxt;
   logic [W-1:0]         beat_data;
   logic [31:0]          lfsr_value;
   logic                 launch, zero_run, load_beat;
   logic                 xfer, pkt_done, run_done, word_last;

   // Handshake: a beat moves on a rising edge where TVALID and TREADY are both 1.
   // Once TVALID is raised it stays high, with TDATA/TLAST frozen, until that
   // transfer happens; TVALID never depends combinationally on TREADY.
   assign xfer      = M_AXIS_TVALID & M_AXIS_TREADY;
   assign pkt_done  = xfer & M_AXIS_TLAST;
   assign run_done  = pkt_done & ((pkt_count + 16'd1) == pkts_q);
   assign launch    = (state == ST_IDLE) & start;
   assign zero_run  = (cfg_len == '0) | (cfg_pkts == 16'd0);
   assign word_last = (word_nxt == (len_q - LEN_WIDTH'(1)));

   assign M_AXIS_TSTRB = '1;
   assign state_dbg    = state;

   always_comb begin
      state_n   = state;
      load_beat = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !zero_run) state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt == WAIT_W'(C_M_START_COUNT - 1)) begin
               state_n   = ST_SEND;
               load_beat = 1'b1;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (run_done) begin
                  state_n = ST_IDLE;
               end else if (pkt_done && (gap_q != '0)) begin
                  state_n = ST_GAP;
               end else begin
                  load_beat = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt == (gap_q - GAP_WIDTH'(1))) begin
               state_n   = ST_SEND;
               load_beat = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      beat_data = beat_nxt;
      case (mode_q)
         MODE_LFSR: begin
            for (int i = 0; i < W; i++) beat_data[i] = lfsr_value[i % 32];
         end
         MODE_IDX: beat_data = {HALF'(pkt_nxt), HALF'(word_nxt)};
         default:  beat_data = beat_nxt;
      endcase
   end

   axis_gen_lfsr u_lfsr (
      .clk     (M_AXIS_ACLK),
      .rst     (M_AXIS_ARESET),
      .load    (launch),
      .advance (load_beat),
      .value   (lfsr_value)
   );

   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         state         <= ST_IDLE;
         len_q         <= '0;
         pkts_q        <= '0;
         gap_q         <= '0;
         mode_q        <= '0;
         wait_cnt      <= '0;
         gap_cnt       <= '0;
         word_nxt      <= '0;
         pkt_nxt       <= '0;
         beat_nxt      <= '0;
         pkt_count     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TLAST  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != ST_IDLE);
         done  <= run_done;
         if (launch) begin
            len_q     <= cfg_len;
            pkts_q    <= cfg_pkts;
            gap_q     <= cfg_gap;
            mode_q    <= cfg_mode;
            pkt_count <= '0;
            word_nxt  <= '0;
            pkt_nxt   <= '0;
            beat_nxt  <= W'(1);
            wait_cnt  <= '0;
            done      <= zero_run;
         end
         if (state == ST_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
         gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_WIDTH'(1) : '0;
         if (pkt_done) pkt_count <= pkt_count + 16'd1;
         if (load_beat) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= beat_data;
            M_AXIS_TLAST  <= word_last;
            beat_nxt      <= beat_nxt + W'(1);
            if (word_last) begin
               word_nxt <= '0;
               pkt_nxt  <= pkt_nxt + 16'd1;
            end else begin
               word_nxt <= word_nxt + LEN_WIDTH'(1);
            end
         end else if (state_n != ST_SEND) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: directed and randomized runs
// scored against a packet-level model of the expected beat stream.
module tb_axis_pattern_gen;
   import axis_gen_pkg::*;

   localparam int W         = 32;
   localparam int START_CNT = 32;
   localparam int LW        = 8;
   localparam int GW        = 8;
   localparam int HALF      = W / 2;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] cfg_len = '0;
   logic [15:0]   cfg_pkts = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic [1:0]    cfg_mode = '0;
   logic          tvalid, tlast, tready = 1'b0;
   logic [W-1:0]  tdata;
   logic [W/8-1:0] tstrb;
   logic          busy, done;
   logic [15:0]   pkt_count;
   gen_state_t    state_dbg;

   always #5 clk = ~clk;

   axis_pattern_gen #(
      .C_M_AXIS_TDATA_WIDTH (W),
      .C_M_START_COUNT      (START_CNT),
      .LEN_WIDTH            (LW),
      .GAP_WIDTH            (GW)
   ) dut (
      .M_AXIS_ACLK   (clk),
      .M_AXIS_ARESET (rst),
      .start         (start),
      .cfg_len       (cfg_len),
      .cfg_pkts      (cfg_pkts),
      .cfg_gap       (cfg_gap),
      .cfg_mode      (cfg_mode),
      .M_AXIS_TVALID (tvalid),
      .M_AXIS_TDATA  (tdata),
      .M_AXIS_TSTRB  (tstrb),
      .M_AXIS_TLAST  (tlast),
      .M_AXIS_TREADY (tready),
      .busy          (busy),
      .done          (done),
      .pkt_count     (pkt_count),
      .state_dbg     (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] exp_q[$];
   logic         exp_last_q[$];
   logic [W-1:0] cap_q[$];
   int           since = 0;
   bit           run_active = 0, run_zero = 0, first_pending = 0;
   bit           m_busy = 0, done_pending = 0, gap_active = 0, prev_stall = 0;
   int           m_gap = 0, gap_seen = 0, beats_xfer = 0, rdy_pct = 100;
   logic [15:0]  m_pkt = '0;
   logic [W-1:0] prev_d = '0;
   logic         prev_l = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic build_model(input int len, input int pkts, input int mode);
      logic [31:0] l;
      logic [W-1:0] d;
      int g;
      l = 32'h1;
      g = 1;
      exp_q.delete();
      exp_last_q.delete();
      for (int p = 0; p < pkts; p++) begin
         for (int w = 0; w < len; w++) begin
            case (mode)
               1:       d = l;
               2:       d = {HALF'(p), HALF'(w)};
               default: d = W'(g);
            endcase
            exp_q.push_back(d);
            exp_last_q.push_back(w == len - 1);
            g++;
            l = lfsr_next(l);
         end
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_last_q.delete();
      run_active    = 0;
      run_zero      = 0;
      first_pending = 0;
      m_busy        = 0;
      done_pending  = 0;
      gap_active    = 0;
      prev_stall    = 0;
   endtask

   // ---------------- compare process (outputs sampled on falling edge) ----------------
   always @(negedge clk) begin : cmp
      bit   exp_done;
      logic b_last;
      if (!rst) begin
         since++;
         check("tstrb", W'(tstrb), W'((1 << (W / 8)) - 1));
         exp_done     = done_pending || (run_active && run_zero && since == 1);
         done_pending = 0;
         check("done", W'(done), W'(exp_done));
         if (exp_done) begin
            m_busy     = 0;
            run_active = 0;
            run_zero   = 0;
         end
         if (run_active && !run_zero && since == 1) m_busy = 1;
         check("busy", W'(busy), W'(m_busy));
         check("state_busy", W'(state_dbg != ST_IDLE), W'(m_busy));
         if (m_busy || exp_done) check("pkt_count", W'(pkt_count), W'(m_pkt));
         if (prev_stall) begin
            check("stall_valid", W'(tvalid), W'(1));
            check("stall_data", tdata, prev_d);
            check("stall_last", W'(tlast), W'(prev_l));
         end
         if (tvalid) begin
            if (first_pending) begin
               check("first_valid_cycle", W'(since), W'(START_CNT + 1));
               first_pending = 0;
            end
            if (gap_active) begin
               check("gap_len", W'(gap_seen), W'(m_gap));
               gap_active = 0;
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got tvalid=1 tdata=%0h expected no beat (t=%0t)", tdata, $time);
            end else begin
               check("tdata", tdata, exp_q[0]);
               check("tlast", W'(tlast), W'(exp_last_q[0]));
            end
         end else if (gap_active) begin
            gap_seen++;
         end
         tready     = ($urandom_range(99) < rdy_pct);
         prev_stall = tvalid && !tready;
         prev_d     = tdata;
         prev_l     = tlast;
         if (tvalid && tready && exp_q.size() > 0) begin
            cap_q.push_back(tdata);
            b_last = exp_last_q[0];
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            beats_xfer++;
            if (b_last) begin
               m_pkt++;
               if (exp_q.size() == 0) begin
                  done_pending = 1;
               end else begin
                  gap_active = 1;
                  gap_seen   = 0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_run(input int len, input int pkts, input int gap, input int mode, input int pct);
      @(posedge clk); #1;
      build_model(len, pkts, mode);
      cap_q.delete();
      m_pkt         = '0;
      m_gap         = gap;
      rdy_pct       = pct;
      beats_xfer    = 0;
      run_zero      = (len == 0) || (pkts == 0);
      first_pending = !run_zero;
      run_active    = 1;
      since         = -1;
      cfg_len       = LW'(len);
      cfg_pkts      = 16'(pkts);
      cfg_gap       = GW'(gap);
      cfg_mode      = 2'(mode);
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_run_end(input int budget);
      int n;
      n = 0;
      while (run_active && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (run_active) begin
         errors++;
         $display("FAIL run_timeout: still running after %0d cycles, expected done", n);
         pulse_reset();
      end
      check("queue_drained", W'(exp_q.size()), W'(0));
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int n;
      #1 rst = 1'b1;
      #2;
      check("rst_tvalid", W'(tvalid), W'(0));
      check("rst_tlast", W'(tlast), W'(0));
      check("rst_tdata", tdata, W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_pkt_count", W'(pkt_count), W'(0));
      check("rst_state", W'(state_dbg), W'(ST_IDLE));
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);

      // single 8-word incrementing packet, always ready
      do_run(8, 1, 0, 0, 100);
      wait_run_end(500);
      check("pin_inc_count", W'(cap_q.size()), W'(8));
      check("pin_inc_first", cap_q[0], W'(1));
      check("pin_inc_last", cap_q[7], W'(8));
      check("pin_inc_pkt_count", W'(pkt_count), W'(1));

      // three back-to-back indexed packets
      do_run(4, 3, 0, 2, 100);
      wait_run_end(500);
      check("pin_idx_count", W'(cap_q.size()), W'(12));
      check("pin_idx_3", cap_q[3], 32'h0000_0003);
      check("pin_idx_4", cap_q[4], 32'h0001_0000);
      check("pin_idx_11", cap_q[11], 32'h0002_0003);

      // 5-cycle inter-packet gap
      do_run(2, 2, 5, 0, 100);
      wait_run_end(500);

      // LFSR pattern with 50% backpressure
      do_run(6, 2, 1, 1, 50);
      wait_run_end(1000);
      check("pin_lfsr_0", cap_q[0], 32'h0000_0001);
      check("pin_lfsr_1", cap_q[1], 32'h8020_0003);
      check("pin_lfsr_2", cap_q[2], 32'hC030_0002);

      // zero-length and zero-packet runs
      do_run(0, 3, 0, 0, 100);
      wait_run_end(20);
      do_run(3, 0, 0, 0, 100);
      wait_run_end(20);

      // start while busy must be ignored
      do_run(3, 2, 1, 0, 100);
      repeat (10) @(posedge clk);
      #1;
      cfg_len  = LW'(1);
      cfg_pkts = 16'd5;
      cfg_mode = 2'd2;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_run_end(500);

      // asynchronous reset after the 3rd beat of a packet
      do_run(8, 2, 0, 0, 100);
      n = 0;
      while (beats_xfer < 3 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_reset_reached", W'(beats_xfer >= 3), W'(1));
      rst = 1'b1;
      model_clear();
      #1;
      check("arst_tvalid", W'(tvalid), W'(0));
      check("arst_tlast", W'(tlast), W'(0));
      check("arst_tdata", tdata, W'(0));
      check("arst_busy", W'(busy), W'(0));
      check("arst_pkt_count", W'(pkt_count), W'(0));
      check("arst_state", W'(state_dbg), W'(ST_IDLE));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;

      // randomized runs
      for (int r = 0; r < 10; r++) begin
         int pct;
         case ($urandom_range(2))
            0:       pct = 100;
            1:       pct = 50;
            default: pct = 75;
         endcase
         do_run($urandom_range(6, 1), $urandom_range(4, 1), $urandom_range(3), $urandom_range(3), pct);
         wait_run_end(2000);
      end

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
